// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types for the pipeline hazard sequencer.
//   - stage_idx_e   : bit position of each pipeline stage inside a stage vector
//                     (F is the MSB, W the LSB).
//   - stage_ctrl_t  : 5-bit packed per-stage control vector {F,D,E,M,W}.
//   - hctrl_state_t : sequencer state (RUN, DRAIN).
//   - ADDR_W_DEF    : default redirect-target width, the core's address width.
//   - CNT_W_DEF     : default perf counter width (used only with PERF_CNT_EN).
package hazard_ctrl_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_W = 3'd0,
    ST_M = 3'd1,
    ST_E = 3'd2,
    ST_D = 3'd3,
    ST_F = 3'd4
  } stage_idx_e;

  typedef logic [4:0] stage_ctrl_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hctrl_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundle between the pipeline and the hazard sequencer.
//   Pipeline -> sequencer : bubble_a, bubble_b, i_busy, d_busy, md_busy,
//                           br_valid, br_target.
//   Sequencer -> pipeline : stall, flush ({F,D,E,M,W}), pc_redir_valid,
//                           pc_redir, fetch_discard.
//   Handshake: every signal is a per-cycle level, there is no valid/ready
//   pairing. br_valid is a request that the execute stage keeps presenting
//   until it is honoured; it is honoured exactly in a cycle where stall[E]=0,
//   otherwise E holds and re-presents it. pc_redir_valid is a one-cycle
//   command to fetch; pc_redir is only meaningful while it is 1.
//   Modports: master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              bubble_a;
  logic              bubble_b;
  logic              i_busy;
  logic              d_busy;
  logic              md_busy;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;

  stage_ctrl_t       stall;
  stage_ctrl_t       flush;
  logic              pc_redir_valid;
  logic [ADDR_W-1:0] pc_redir;
  logic              fetch_discard;

  modport master (
    output bubble_a, bubble_b, i_busy, d_busy, md_busy, br_valid, br_target,
    input  stall, flush, pc_redir_valid, pc_redir, fetch_discard
  );

  modport slave (
    input  bubble_a, bubble_b, i_busy, d_busy, md_busy, br_valid, br_target,
    output stall, flush, pc_redir_valid, pc_redir, fetch_discard
  );

endinterface

// File: rtl/hazard_ctrl_perf_sat_cnt.sv
// perf_sat_cnt
//   Single saturating event counter: counts up on inc and sticks at all-ones.
//   Only compiled when PERF_CNT_EN is defined, since that is the only build
//   that instantiates it.
//   Ports: clk, reset (async, active-low), inc (count enable), cnt (value).
`ifdef PERF_CNT_EN
module perf_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Central stall/flush sequencer for the 5-stage F/D/E/M/W core.
//   Ports:
//     clk        : clock
//     reset      : asynchronous active-low reset
//     hif        : hazard_ctrl_if.slave (hazard inputs, stall/flush/redirect)
//     state_dbg  : current sequencer state (RUN / DRAIN)
//     cnt_loaduse, cnt_membusy, cnt_redirect : saturating perf counters,
//                  present only when PERF_CNT_EN is defined.
//   Priority of hold requests (highest first): d_busy, md_busy, load-use
//   bubble, i_busy. A taken branch is honoured only when E is not held; it
//   then squashes D and E. If a fetch is still in flight when the branch
//   resolves, the target is parked and replayed (DRAIN) once the fetch
//   returns, with that returning response marked stale.
//   Optional feature macro: PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif,
  output hctrl_state_t state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_membusy,
  output logic [CNT_W-1:0] cnt_redirect
`endif
);

  hctrl_state_t      state_q;
  logic [ADDR_W-1:0] pend_q;

  stage_ctrl_t       stall_c;
  stage_ctrl_t       flush_c;
  logic              br_take;
  logic              redir_c;
  logic [ADDR_W-1:0] tgt_c;
  logic              discard_c;
  logic              loaduse_c;

  assign loaduse_c = (hif.bubble_a | hif.bubble_b) & ~hif.d_busy & ~hif.md_busy;

  always_comb begin
    stall_c   = '0;
    flush_c   = '0;
    br_take   = 1'b0;
    redir_c   = 1'b0;
    tgt_c     = '0;
    discard_c = 1'b0;

    // Each rule holds every stage upstream of the blocked one and inserts a
    // bubble into the stage just downstream of it.
    if (hif.d_busy) begin
      stall_c = 5'b11110;
      flush_c = 5'b00001;
    end else if (hif.md_busy) begin
      stall_c = 5'b11100;
      flush_c = 5'b00010;
    end else if (hif.bubble_a || hif.bubble_b) begin
      stall_c = 5'b11000;
      flush_c = 5'b00100;
    end else if (hif.i_busy) begin
      stall_c = 5'b10000;
      flush_c = 5'b01000;
    end

    // A branch sitting in a held E stage is not acted on; E keeps it.
    br_take = hif.br_valid & ~stall_c[ST_E];
    if (br_take) begin
      stall_c[ST_D] = 1'b0;
      stall_c[ST_E] = 1'b0;
      flush_c[ST_D] = 1'b1;
      flush_c[ST_E] = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (br_take && !hif.i_busy) begin
          redir_c = 1'b1;
          tgt_c   = hif.br_target;
        end
      end
      DRAIN: begin
        if (!hif.i_busy) begin
          // The response arriving now belongs to the wrong path. A branch
          // resolving in this same cycle is younger than the parked one.
          discard_c = 1'b1;
          redir_c   = 1'b1;
          tgt_c     = br_take ? hif.br_target : pend_q;
        end
      end
      default: begin
        redir_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (br_take && hif.i_busy) begin
            state_q <= DRAIN;
            pend_q  <= hif.br_target;
          end
        end
        DRAIN: begin
          if (!hif.i_busy) begin
            state_q <= RUN;
          end else if (br_take) begin
            pend_q <= hif.br_target;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so the pipeline sees a
  // quiet sequencer immediately, not only after the next clock.
  assign hif.stall          = reset ? stall_c   : '0;
  assign hif.flush          = reset ? flush_c   : '0;
  assign hif.pc_redir_valid = reset ? redir_c   : 1'b0;
  assign hif.pc_redir       = reset ? tgt_c     : '0;
  assign hif.fetch_discard  = reset ? discard_c : 1'b0;
  assign state_dbg          = state_q;

`ifdef PERF_CNT_EN
  perf_sat_cnt #(.W(CNT_W)) u_cnt_loaduse (
    .clk   (clk),
    .reset (reset),
    .inc   (loaduse_c),
    .cnt   (cnt_loaduse)
  );

  perf_sat_cnt #(.W(CNT_W)) u_cnt_membusy (
    .clk   (clk),
    .reset (reset),
    .inc   (hif.d_busy),
    .cnt   (cnt_membusy)
  );

  perf_sat_cnt #(.W(CNT_W)) u_cnt_redirect (
    .clk   (clk),
    .reset (reset),
    .inc   (redir_c),
    .cnt   (cnt_redirect)
  );
`else
  // Without counters the load-use term and CNT_W have no consumer.
  logic unused_perf;
  assign unused_perf = loaduse_c;
  if (CNT_W > 0) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW = 64;
  localparam int W  = 5 + 5 + 1 + AW + 1 + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  hctrl_state_t state_dbg;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_W(AW)) hif ();

`ifdef PERF_CNT_EN
  logic [31:0] cnt_loaduse, cnt_membusy, cnt_redirect;
`endif

  hazard_ctrl #(.ADDR_W(AW), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .hif       (hif),
    .state_dbg (state_dbg)
`ifdef PERF_CNT_EN
    ,
    .cnt_loaduse  (cnt_loaduse),
    .cnt_membusy  (cnt_membusy),
    .cnt_redirect (cnt_redirect)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: does fetch have a parked redirect, and to where.
  bit          m_drain = 1'b0;
  logic [AW-1:0] m_pend = '0;

  function automatic logic [W-1:0] pack_out(
    input logic [4:0] st, input logic [4:0] fl, input logic prv,
    input logic [AW-1:0] pc, input logic fd, input logic sd);
    return {st, fl, prv, pc, fd, sd};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return pack_out(hif.stall, hif.flush, hif.pc_redir_valid, hif.pc_redir,
                    hif.fetch_discard, state_dbg);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit ba, input bit bb, input bit ib, input bit db,
                       input bit mb, input bit bv, input logic [AW-1:0] tgt);
    int depth;
    int s;
    logic [4:0] st, fl;
    bit take;
    logic prv, fd;
    logic [AW-1:0] pc;
    @(negedge clk);
    hif.bubble_a  = ba;
    hif.bubble_b  = bb;
    hif.i_busy    = ib;
    hif.d_busy    = db;
    hif.md_busy   = mb;
    hif.br_valid  = bv;
    hif.br_target = tgt;

    // Hold depth = number of stages frozen from F downwards; the stage right
    // after the frozen ones gets a bubble.
    depth = db ? 4 : mb ? 3 : (ba | bb) ? 2 : ib ? 1 : 0;
    s  = ((1 << depth) - 1) << (5 - depth);
    st = s[4:0];
    s  = (depth > 0) ? (1 << (4 - depth)) : 0;
    fl = s[4:0];
    take = bv && (depth < 3);
    if (take) begin
      st = st & 5'b10000;
      fl = fl | 5'b01100;
    end

    prv = 1'b0;
    pc  = '0;
    fd  = 1'b0;
    if (!m_drain) begin
      if (take && !ib) begin
        prv = 1'b1;
        pc  = tgt;
      end
      exp_q.push_back(pack_out(st, fl, prv, pc, fd, 1'b0));
      if (take && ib) begin
        m_drain = 1'b1;
        m_pend  = tgt;
      end
    end else begin
      if (!ib) begin
        fd  = 1'b1;
        prv = 1'b1;
        pc  = take ? tgt : m_pend;
      end
      exp_q.push_back(pack_out(st, fl, prv, pc, fd, 1'b1));
      if (!ib) m_drain = 1'b0;
      else if (take) m_pend = tgt;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL %s stall=%b flush=%b prv=%b pc=%h fd=%b state=%b required all zero",
               name, hif.stall, hif.flush, hif.pc_redir_valid, hif.pc_redir,
               hif.fetch_discard, state_dbg);
    end
`ifdef PERF_CNT_EN
    checks++;
    if ({cnt_loaduse, cnt_membusy, cnt_redirect} !== '0) begin
      errors++;
      $display("FAIL %s_cnt loaduse=%0d membusy=%0d redirect=%0d required 0",
               name, cnt_loaduse, cnt_membusy, cnt_redirect);
    end
`endif
  endtask

  // Pulls reset low mid-cycle, after the monitor has sampled the current
  // cycle and well before the next rising edge.
  task automatic reset_mid();
    #3;
    reset = 1'b0;
    #1;
    check_quiet("async_reset");
    m_drain = 1'b0;
    m_pend  = '0;
    @(negedge clk);
    hif.bubble_a = 0; hif.bubble_b = 0; hif.i_busy = 0; hif.d_busy = 0;
    hif.md_busy = 0; hif.br_valid = 0; hif.br_target = '0;
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_out t=%0t stall=%b/%b flush=%b/%b prv=%b/%b pc=%h/%h fd=%b/%b state=%b/%b (actual/required)",
                   $time, a[W-1-:5], e[W-1-:5], a[W-6-:5], e[W-6-:5],
                   a[AW+2], e[AW+2], a[AW+1:2], e[AW+1:2], a[1], e[1], a[0], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    hif.bubble_a = 1; hif.bubble_b = 1; hif.i_busy = 0; hif.d_busy = 1;
    hif.md_busy = 1; hif.br_valid = 1; hif.br_target = 64'h1234;
    #2;
    check_quiet("reset_state");
    hif.bubble_a = 0; hif.bubble_b = 0; hif.d_busy = 0; hif.md_busy = 0;
    hif.br_valid = 0; hif.br_target = '0;
    @(negedge clk);
    reset = 1'b1;

    // load-use bubble then clear
    drive(1, 0, 0, 0, 0, 0, '0);
    idle();
    // data bus wait dominates mul/div and bubble
    repeat (3) drive(0, 1, 0, 1, 1, 0, '0);
    // immediate redirect
    drive(0, 0, 0, 0, 0, 1, 64'h8000_0040);
    // redirect parked behind an in-flight fetch, then replayed
    drive(0, 0, 1, 0, 0, 1, 64'h8000_0100);
    repeat (4) drive(0, 0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 0, '0);
    idle();
    // mul/div holds E: branch waits, then goes
    drive(0, 0, 0, 0, 1, 1, 64'h8000_0200);
    drive(0, 0, 0, 0, 0, 1, 64'h8000_0200);
    // redirect honoured past a load-use bubble
    drive(1, 1, 0, 0, 0, 1, 64'h8000_0300);
    // second redirect overwrites a parked one
    drive(0, 0, 1, 0, 0, 1, 64'h8000_0400);
    drive(0, 0, 1, 0, 0, 1, 64'h8000_0480);
    drive(0, 0, 0, 0, 0, 0, '0);
    // reset while draining: nothing stale afterwards
    drive(0, 0, 1, 0, 0, 1, 64'h8000_0500);
    drive(0, 0, 1, 0, 0, 0, '0);
    reset_mid();
    repeat (3) idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 30,
            {$urandom, $urandom_range(0, 65535) << 2});
    end
    idle();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (F/D/E/M/W).
- Collects three kinds of input:
  - load-use bubble requests from the per-operand forwarding selects in decode,
  - bus wait signals and the multi-cycle mul/div busy signal,
  - branch redirects from execute.
- Produces per-stage stall/flush controls and the fetch PC redirect.
- Holds a redirect that arrives while a fetch is still in flight, and replays it once the fetch completes.

Parameters:
- ADDR_W, 64, width of redirect target.
- CNT_W, 32, width of perf counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- bubble_a  in  1  load-use bubble from rs1 select.
- bubble_b  in  1  load-use bubble from rs2 select.
- i_busy  in  1  instruction bus request outstanding, no response yet.
- d_busy  in  1  data bus request outstanding in M.
- md_busy  in  1  mul/div unit in E is iterating.
- br_valid  in  1  execute resolved a taken/mispredicted branch.
- br_target  in  ADDR_W  redirect target.
- stall  out  5  per-stage hold {F,D,E,M,W}; bit set = register keeps its value.
- flush  out  5  per-stage bubble insert {F,D,E,M,W}.
- pc_redir_valid  out  1  fetch must load pc_redir.
- pc_redir  out  ADDR_W  target PC.
- fetch_discard  out  1  the fetch response now returning is stale and must be dropped.

Behaviour:
- Reset values: stall=0, flush=0, pc_redir_valid=0, pc_redir=0, fetch_discard=0, state=RUN, pending target=0.
- stall/flush are combinational from the inputs and the registered state; the state and pending target are registered.
- Priority, highest first:
  1. d_busy: stall F,D,E,M; flush W.
  2. md_busy: stall F,D,E; flush M.
  3. bubble_a|bubble_b: stall F,D; flush E.
  4. i_busy: stall F; flush D.
- br_valid is honoured only when stall[E]=0. If E is held by a rule above, the redirect is ignored and E re-presents it next cycle.
- Honoured redirect: flush D and E in the same cycle (squashes the wrong-path instructions in F and D). This overrides any stall on D/E from rules 3/4.
- FSM states: RUN, DRAIN.
  - RUN, honoured br_valid, i_busy=0: pc_redir_valid=1 and pc_redir=br_target in the same cycle; stay in RUN.
  - RUN, honoured br_valid, i_busy=1: latch br_target; go to DRAIN; pc_redir_valid=0.
  - DRAIN, i_busy=1: stall F, flush D, pc_redir_valid=0.
  - DRAIN, i_busy=0: fetch_discard=1, pc_redir_valid=1, pc_redir=latched target; go to RUN.
  - A second honoured br_valid while in DRAIN overwrites the latched target (youngest-resolving redirect wins). This can only occur after E refills.
- Simultaneous bubble and d_busy: d_busy wins; no E flush, because E is stalled.
- Reset mid-DRAIN: return to RUN and drop the pending target. Fetch restarts from the reset PC.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined, adds three saturating counters of width CNT_W, readable on extra outputs cnt_loaduse, cnt_membusy, cnt_redirect:
  - cnt_loaduse increments when rule 3 fires,
  - cnt_membusy increments when rule 1 fires,
  - cnt_redirect increments per pc_redir_valid.
- Counters reset to 0 and hold at all-ones.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- pipes package:
  - stage_idx enum (F=4..W=0),
  - stage_ctrl_t (5-bit packed) for stall/flush,
  - hctrl_state_t enum {RUN, DRAIN}.
- common package: ADDR_W default tied to the existing word_t/addr_t width.
- One sub-module, perf_sat_cnt (single saturating counter, width parameter), instantiated three times only under PERF_CNT_EN.

Test Plan:
- bubble_a=1 for 1 cycle, all busy=0 → stall=5'b11000, flush=5'b00100; next cycle both 0.
- d_busy=1 for 3 cycles with bubble_b=1 and md_busy=1 → stall=5'b11110, flush=5'b00001 each cycle; no E flush.
- br_valid=1, br_target=0x8000_0040, i_busy=0 → same cycle pc_redir_valid=1, pc_redir=0x8000_0040, flush=5'b01100.
- br_valid=1, target=0x8000_0100, i_busy=1 for 4 more cycles → 4 cycles in DRAIN with pc_redir_valid=0; then a cycle with fetch_discard=1 and pc_redir=0x8000_0100; state returns to RUN.
- md_busy=1 with br_valid=1 → no redirect, flush=5'b00010; after md_busy drops, br_valid still asserted → redirect issued.
- Reset pulled low during DRAIN → all outputs 0 immediately (asynchronous); after release, no stale redirect appears. With PERF_CNT_EN, counters read 0.
